// File: rtl/cnn_fixed_pkg.sv
// rtl/cnn_fixed_pkg.sv - shared Q1.15 limits, accumulator FSM encoding and saturation helper
package cnn_fixed_pkg;

  localparam logic signed [15:0] Q15_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q15_MIN = 16'sh8000;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACCUM = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    ACCUM = S_ACCUM,
    WAIT  = S_WAIT,
    FINAL = S_FINAL,
    HOLD  = S_HOLD
  } pfm_acc_state_e;

  // Callers sign-extend their wider sums to 32 bits before saturating.
  function automatic logic [15:0] q15_clamp(input logic signed [31:0] s);
    if (s > 32'sd32767)
      return Q15_MAX;
    else if (s < -32'sd32768)
      return Q15_MIN;
    else
      return s[15:0];
  endfunction

endpackage

// File: rtl/pfm_acc_lane.sv
// rtl/pfm_acc_lane.sv - one kernel lane: snapshot, accumulators, bias/ReLU/clamp (PFM_ACC_RELU_EN)
module pfm_acc_lane
  import cnn_fixed_pkg::*;
#(
  parameter int op_size = 4,
  parameter int acc_w   = 24,
  localparam int N      = op_size * op_size,
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             acc_en,
  input  logic             first_ch,
  input  logic             fin_en,
  input  logic             clr,
  input  logic [IDX_W-1:0] idx,
  input  logic [16*N-1:0]  ik,
  input  logic [15:0]      bias,
  output logic [16*N-1:0]  of
);

  logic        [15:0]      snap [N];
  logic signed [acc_w-1:0] acc  [N];
  logic        [15:0]      of_q [N];

  logic signed [acc_w-1:0] snap_x;
  logic signed [acc_w-1:0] acc_nxt;
  logic signed [acc_w:0]   s;
  logic signed [acc_w:0]   s_r;
  logic signed [31:0]      s32;

  // acc_w is limited to 30 so the 32-bit widening below always has sign bits to add.
  always_comb begin
    snap_x  = {{(acc_w-16){snap[idx][15]}}, snap[idx]};
    acc_nxt = first_ch ? snap_x : acc[idx] + snap_x;
    s       = {acc[idx][acc_w-1], acc[idx]} + {{(acc_w-15){bias[15]}}, bias};
`ifdef PFM_ACC_RELU_EN
    s_r     = s[acc_w] ? '0 : s;
`else
    s_r     = s;
`endif
    s32     = {{(31-acc_w){s_r[acc_w]}}, s_r};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < N; e++) begin
        snap[e] <= '0;
        acc[e]  <= '0;
        of_q[e] <= '0;
      end
    end else begin
      if (load)
        for (int e = 0; e < N; e++) snap[e] <= ik[16*e +: 16];
      if (clr)
        for (int e = 0; e < N; e++) acc[e] <= '0;
      else if (acc_en)
        acc[idx] <= acc_nxt;
      if (fin_en)
        of_q[idx] <= q15_clamp(s32);
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_of
    assign of[16*g +: 16] = of_q[g];
  end

endmodule

// File: rtl/partial_fm_accumulator.sv
// rtl/partial_fm_accumulator.sv - sums per-channel partial FMs, adds bias, ReLU (PFM_ACC_RELU_EN), saturates
module partial_fm_accumulator
  import cnn_fixed_pkg::*;
#(
  parameter int op_size      = 4,
  parameter int num_channels = 3,
  parameter int acc_w        = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pfm_valid,
  output logic                          pfm_ready,
  input  logic [16*op_size*op_size-1:0] IK1,
  input  logic [16*op_size*op_size-1:0] IK2,
  input  logic [16*op_size*op_size-1:0] IK3,
  input  logic [15:0]                   b1,
  input  logic [15:0]                   b2,
  input  logic [15:0]                   b3,
  output logic                          fm_valid,
  input  logic                          fm_ready,
  output logic [16*op_size*op_size-1:0] OF1,
  output logic [16*op_size*op_size-1:0] OF2,
  output logic [16*op_size*op_size-1:0] OF3,
  output logic                          busy
);

  localparam int N     = op_size * op_size;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CH_W  = $clog2(num_channels + 1);

  pfm_acc_state_e   state, next_state;
  logic [IDX_W-1:0] idx;
  logic [CH_W-1:0]  chan;
  logic             alive;
  logic             fm_valid_q;
  logic             idx_last, accept, hs_out;

  assign idx_last  = (idx == IDX_W'(N - 1));
  // alive keeps pfm_ready low until the first edge after reset release.
  assign pfm_ready = alive && (state == IDLE || state == WAIT);
  assign accept    = pfm_valid && pfm_ready;
  assign fm_valid  = fm_valid_q;
  assign hs_out    = fm_valid_q && fm_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      chan       <= '0;
      alive      <= 1'b0;
      fm_valid_q <= 1'b0;
    end else begin
      state <= next_state;
      alive <= 1'b1;
      if ((state == ACCUM || state == FINAL) && !idx_last)
        idx <= idx + IDX_W'(1);
      else
        idx <= '0;
      if (state == ACCUM && idx_last)
        chan <= chan + CH_W'(1);
      else if (hs_out)
        chan <= '0;
      if (hs_out)
        fm_valid_q <= 1'b0;
      else if (state == HOLD)
        fm_valid_q <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, WAIT: if (accept) next_state = ACCUM;
      ACCUM:      if (idx_last)
                    next_state = (chan == CH_W'(num_channels - 1)) ? FINAL : WAIT;
      FINAL:      if (idx_last) next_state = HOLD;
      HOLD:       if (hs_out) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  pfm_acc_lane #(.op_size(op_size), .acc_w(acc_w)) u_lane1 (
    .clk(clk), .rst(rst), .load(accept), .acc_en(state == ACCUM), .first_ch(chan == '0),
    .fin_en(state == FINAL), .clr(hs_out), .idx(idx), .ik(IK1), .bias(b1), .of(OF1)
  );

  pfm_acc_lane #(.op_size(op_size), .acc_w(acc_w)) u_lane2 (
    .clk(clk), .rst(rst), .load(accept), .acc_en(state == ACCUM), .first_ch(chan == '0),
    .fin_en(state == FINAL), .clr(hs_out), .idx(idx), .ik(IK2), .bias(b2), .of(OF2)
  );

  pfm_acc_lane #(.op_size(op_size), .acc_w(acc_w)) u_lane3 (
    .clk(clk), .rst(rst), .load(accept), .acc_en(state == ACCUM), .first_ch(chan == '0),
    .fin_en(state == FINAL), .clr(hs_out), .idx(idx), .ik(IK3), .bias(b3), .of(OF3)
  );

endmodule

// File: tb/tb_partial_fm_accumulator.sv
// tb/tb_partial_fm_accumulator.sv - scoreboard bench for partial_fm_accumulator (PFM_ACC_RELU_EN aware)
module tb_partial_fm_accumulator;

  localparam int N = 16;
  localparam int W = 16 * N;
  localparam int LAT = 33;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         pfm_valid = 1'b0;
  logic         pfm_ready;
  logic [W-1:0] IK1 = '0, IK2 = '0, IK3 = '0;
  logic [15:0]  b1 = '0, b2 = '0, b3 = '0;
  logic         fm_valid;
  logic         fm_ready = 1'b1;
  logic [W-1:0] OF1, OF2, OF3;
  logic         busy;

  partial_fm_accumulator #(.op_size(4), .num_channels(3), .acc_w(24)) dut (
    .clk(clk), .rst(rst), .pfm_valid(pfm_valid), .pfm_ready(pfm_ready),
    .IK1(IK1), .IK2(IK2), .IK3(IK3), .b1(b1), .b2(b2), .b3(b3),
    .fm_valid(fm_valid), .fm_ready(fm_ready), .OF1(OF1), .OF2(OF2), .OF3(OF3), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int acc_cyc = 0;

  typedef struct {
    logic [W-1:0] o1;
    logic [W-1:0] o2;
    logic [W-1:0] o3;
  } exp_t;
  exp_t sb[$];

  function automatic logic [W-1:0] fill(input logic [15:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[16*i +: 16] = v;
    return r;
  endfunction

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares each new fm_valid presentation against the oldest expectation.
  initial begin
    logic seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && fm_valid && !seen) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_fm: fm_valid with empty scoreboard at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          check_vec("OF1", OF1, e.o1);
          check_vec("OF2", OF2, e.o2);
          check_vec("OF3", OF3, e.o3);
          check_int("latency", cyc - acc_cyc, LAT);
        end
      end
      seen = fm_valid;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [15:0] v);
    int t;
    IK1 = fill(v);
    IK2 = fill(v);
    IK3 = fill(v);
    pfm_valid = 1'b1;
    t = 0;
    while (!pfm_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!pfm_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: pfm_ready 0 expected 1");
    end
    @(negedge clk);
    acc_cyc = cyc;
    pfm_valid = 1'b0;
  endtask

  task automatic run3(input logic [15:0] v, input logic [15:0] c1, input logic [15:0] c2,
                      input logic [15:0] c3, input logic [15:0] e1, input logic [15:0] e2,
                      input logic [15:0] e3);
    exp_t e;
    b1 = c1;
    b2 = c2;
    b3 = c3;
    e.o1 = fill(e1);
    e.o2 = fill(e2);
    e.o3 = fill(e3);
    sb.push_back(e);
    for (int k = 0; k < 3; k++) send(v);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((sb.size() != 0 || busy || fm_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_int(name, (sb.size() == 0 && !busy && !fm_valid) ? 1 : 0, 1);
  endtask

  initial begin
    logic [15:0] neg_exp;
    int t;
`ifdef PFM_ACC_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'h8000;
`endif
    repeat (3) @(negedge clk);
    check_int("rst_pfm_ready", int'(pfm_ready), 0);
    check_int("rst_fm_valid", int'(fm_valid), 0);
    check_int("rst_busy", int'(busy), 0);
    check_vec("rst_of", OF1 | OF2 | OF3, '0);
    rst = 1'b1;
    #1 check_int("release_pfm_ready", int'(pfm_ready), 0);
    @(negedge clk);
    check_int("first_edge_pfm_ready", int'(pfm_ready), 1);

    run3(16'h1000, 16'h0000, 16'h0000, 16'h0000, 16'h3000, 16'h3000, 16'h3000);
    wait_done("t1_done");
    run3(16'h7000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    wait_done("t2_done");
    run3(16'hC000, 16'h0000, 16'h0000, 16'h0000, neg_exp, neg_exp, neg_exp);
    wait_done("t3_done");
    run3(16'h0100, 16'h0200, 16'hFF00, 16'h0000, 16'h0500, 16'h0200, 16'h0300);
    wait_done("t4_done");

    fm_ready = 1'b0;
    run3(16'h0200, 16'h0000, 16'h0000, 16'h0000, 16'h0600, 16'h0600, 16'h0600);
    t = 0;
    while (!fm_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_int("t5_fm_valid_rise", int'(fm_valid), 1);
    for (int i = 0; i < 10; i++) begin
      pfm_valid = i[0];
      IK1 = fill(16'h1111);
      IK2 = fill(16'h2222);
      IK3 = fill(16'h3333);
      @(negedge clk);
      check_int("t5_hold_valid", int'(fm_valid), 1);
      check_int("t5_hold_pfm_ready", int'(pfm_ready), 0);
      check_vec("t5_hold_of1", OF1, fill(16'h0600));
      check_vec("t5_hold_of3", OF3, fill(16'h0600));
    end
    pfm_valid = 1'b0;
    fm_ready = 1'b1;
    @(negedge clk);
    check_int("t5_after_valid", int'(fm_valid), 0);
    check_int("t5_after_busy", int'(busy), 0);
    check_int("t5_after_pfm_ready", int'(pfm_ready), 1);
    check_vec("t5_after_of2", OF2, fill(16'h0600));
    repeat (3) @(negedge clk);
    check_int("t5_ignored_busy", int'(busy), 0);

    b1 = 16'h0000;
    b2 = 16'h0000;
    b3 = 16'h0000;
    send(16'h0400);
    send(16'h0400);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check_int("t6_rst_fm_valid", int'(fm_valid), 0);
    check_int("t6_rst_busy", int'(busy), 0);
    check_int("t6_rst_pfm_ready", int'(pfm_ready), 0);
    check_vec("t6_rst_of", OF1 | OF2 | OF3, '0);
    @(negedge clk);
    rst = 1'b1;
    #1 check_int("t6_release_pfm_ready", int'(pfm_ready), 0);
    @(negedge clk);
    check_int("t6_edge_pfm_ready", int'(pfm_ready), 1);
    run3(16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'h1800, 16'h1800, 16'h1800);
    wait_done("t6_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/partial_fm_accumulator.md
Name: partial_fm_accumulator

Overview:
- Sits directly downstream of the pipelined partial-FM producer.
- Takes the three flattened Q1.15 partial feature maps (one per kernel) that the producer emits once per input channel, and sums them element-wise across num_channels input channels.
- Adds a per-kernel bias, applies ReLU and Q1.15 saturation, then presents the three finished output feature maps with a valid/ready handshake.

Parameters:
- op_size, 4, side of each square partial FM (elements per map = op_size*op_size).
- num_channels, 3, input channels accumulated per output FM (>=1).
- acc_w, 24, signed accumulator width per element.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pfm_valid  in  1  partial FMs on IK1..IK3 valid.
- pfm_ready  out  1  block can capture a channel.
- IK1  in  16*op_size*op_size  kernel-1 partial FM, element e at bits [16*(e+1)-1 -: 16].
- IK2  in  16*op_size*op_size  kernel-2 partial FM, same packing.
- IK3  in  16*op_size*op_size  kernel-3 partial FM, same packing.
- b1  in  16  kernel-1 bias, Q1.15.
- b2  in  16  kernel-2 bias, Q1.15.
- b3  in  16  kernel-3 bias, Q1.15.
- fm_valid  out  1  final FMs on OF1..OF3 valid.
- fm_ready  in  1  consumer accepts final FMs.
- OF1  out  16*op_size*op_size  kernel-1 final FM, same packing as IK1.
- OF2  out  16*op_size*op_size  kernel-2 final FM, same packing.
- OF3  out  16*op_size*op_size  kernel-3 final FM, same packing.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state IDLE; all accumulators, snapshot registers, OF1..OF3, element and channel counters = 0.
  - pfm_ready=0, fm_valid=0, busy=0.
  - pfm_ready rises on the first clk edge after rst is released.
- Reset mid-operation: all work is discarded. No partial result is ever presented.
- States: IDLE, ACCUM, WAIT, FINAL, HOLD.
- IDLE/WAIT: pfm_ready=1.
  - On pfm_valid&&pfm_ready at edge N: IK1..IK3 are copied into snapshot registers (producer free after N), pfm_ready drops, state goes to ACCUM.
- ACCUM: one element index e per cycle, all three kernels in parallel; e runs 0..op_size^2-1 over cycles N+1..N+op_size^2.
  - Channel 0 loads acc[e] = sext(snapshot[e]).
  - Later channels do acc[e] = acc[e] + sext(snapshot[e]), with 16-bit values sign-extended to acc_w.
  - After the last element: channel counter increments. State goes to WAIT if channels remain, otherwise to FINAL.
- FINAL: one element per cycle over op_size^2 cycles.
  - s = acc[e] + sext(bias).
  - ReLU as per the optional feature.
  - Clamp: s > 32767 gives 0x7FFF; s < -32768 gives 0x8000; otherwise s[15:0].
  - Result is written to OF element e.
- HOLD: fm_valid=1 from the edge after the final FINAL cycle.
  - OF1..OF3 are held stable and pfm_ready=0 while fm_valid && !fm_ready.
  - On fm_valid&&fm_ready: fm_valid drops, accumulators and counters clear, state goes to IDLE. OF1..OF3 keep their last values until the next FINAL pass.
- Latency:
  - Last channel accepted at edge N gives fm_valid at edge N+2*op_size^2+1 (N+33 for defaults).
  - Minimum spacing between accepted channels is op_size^2+1 cycles.
- pfm_valid while pfm_ready=0 is ignored. The producer must hold pfm_valid until accepted.
- num_channels=1: ACCUM goes straight to FINAL; WAIT is never entered.
- Bias is sampled during FINAL and must be stable from the last accept until fm_valid.
- Overflow: acc_w=24 holds up to 256 channels of full-scale inputs without wrap. Larger num_channels requires a larger acc_w.

Optional Feature:
- Macro PFM_ACC_RELU_EN.
- Defined: in FINAL, s<0 is forced to 0 before the clamp, so outputs are in [0x0000, 0x7FFF].
- Undefined: no ReLU; signed saturation only, so outputs are in [0x8000, 0x7FFF].

Decomposition:
- Shared package cnn_fixed_pkg holds:
  - Q15_MAX=16'sh7FFF and Q15_MIN=16'sh8000;
  - the state encoding localparams (IDLE, ACCUM, WAIT, FINAL, HOLD);
  - the clamp function, which is also reused by the partial-FM producer.
- Sub-module pfm_acc_lane: one kernel lane holding the snapshot, accumulator array and bias/ReLU/clamp datapath, indexed by the shared element counter.
  - Instantiated 3 times.
  - The top level owns the FSM, counters and handshakes.

Test Plan:
1. All IK elements 0x1000 for 3 channels, biases 0 -> every OF element 0x3000; fm_valid 33 cycles after the third accept.
2. All IK elements 0x7000 for 3 channels, biases 0 -> sum 0x15000 clamps to 0x7FFF on all 48 outputs.
3. All IK elements 0xC000 for 3 channels, biases 0 -> with PFM_ACC_RELU_EN every OF element is 0x0000; without it -1.5 clamps to 0x8000.
4. IK elements 0x0100, b1=0x0200, b2=0xFF00, b3=0 -> OF1 0x0500, OF2 0x0200, OF3 0x0300.
5. fm_ready held low 10 cycles after fm_valid, pfm_valid pulsed meanwhile -> fm_valid and OF stable, pfm_ready=0, input ignored; accepted on the fm_ready cycle, then IDLE.
6. rst pulsed low during ACCUM of channel 1 -> immediately all outputs 0, fm_valid=0, busy=0. pfm_ready=1 one edge after release. A new 3-channel run then gives correct sums with no residue.
